ext_bus_sequencer: RTL and testbench
====================================

# ext_bus_sequencer

Two-port arbiter and byte-serial sequencer that shares the chip's single 8-bit external bus between two 32-bit requesters (e.g. instruction fetch and data port of the CPU core). It grants one requester at a time using round-robin. It serializes the granted transaction as address bytes, a command byte and data bytes, then returns an `ack` pulse and, for reads, the assembled 32-bit read word. It sits between the CPU-side ports and the top-level `uo_out`/`uio_*` pins.

## Interface
Parameters: none.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0`, `req1` in 1: transaction request, level-sensitive.
- `we0`, `we1` in 1: 1 = write, 0 = read. Sampled at grant.
- `addr0`, `addr1` in 32: byte address. Sampled at grant.
- `wdata0`, `wdata1` in 32: write data. Sampled at grant.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `rdata0`, `rdata1` out 32: read result. Valid in the `ack` cycle; held until that port's next read completes.
- `gnt` out 2: one-hot owner of the current transaction; 0 in IDLE.
- `busy` out 1: high when state ≠ IDLE.
- `pad_addr` out 8: address/command byte lane (drives `uo_out`).
- `pad_dout` out 8: write data byte lane (drives `uio_out`).
- `pad_din` in 8: read data byte lane (from `uio_in`).
- `pad_oe` out 8: bidirectional enable (to `uio_oe`); 8'hFF or 8'h00 only.

## Operation
- States: IDLE, ADDR, CMD, DATA, DONE. A 2-bit byte index `k` is used in ADDR and DATA.
- All outputs are Moore outputs decoded from registered state and latched registers. Nothing is combinational from inputs.
- **IDLE:**
  - Eligible port = `req` high, excluding the port acked in the immediately preceding DONE (one-cycle hold-off).
  - If one port is eligible, it wins.
  - If both are eligible, the port not granted last wins. The `last_grant` pointer resets to port 1, so port 0 wins the first tie.
  - On a win, at the clock edge: latch `addr`, `wdata` and `we` of the winner; set `gnt`; update `last_grant`; go to ADDR with k=0.
- **ADDR (4 cycles):**
  - `pad_addr` = latched address byte k, LSB first.
  - `pad_oe` = 0 and `pad_dout` = 0.
  - After k=3, go to CMD.
- **CMD (1 cycle):**
  - `pad_addr` = {1'b1, 6'b0, we}, i.e. 8'h81 for a write, 8'h80 for a read.
  - `pad_oe` = 0.
- **DATA (4 cycles, k=0..3, LSB first):**
  - Write: `pad_oe` = 8'hFF; `pad_dout` = wdata byte k.
  - Read: `pad_oe` = 0; `pad_dout` = 0; `pad_din` is captured into read buffer byte k at the end of each cycle.
  - `pad_addr` = 0 in DATA.
- **DONE (1 cycle):**
  - `ack` of the owner = 1.
  - For a read, `rdata` of the owner is updated from the buffer and is valid in this cycle.
  - `pad_oe` = 0.
  - Next state is IDLE; `gnt` clears on entry to IDLE.
- Request semantics:
  - `req` dropping after grant does not abort the transaction; it still completes and acks.
  - `req` dropping before it is sampled in IDLE means no transaction.
  - A requester that keeps `req` high after its `ack` gets a new transaction. If the other port is requesting, that port wins first because of the hold-off.
- Writes never modify `rdata`.

## Timing
- Request sampled in IDLE at cycle T:
  - ADDR in T+1..T+4.
  - CMD in T+5.
  - DATA in T+6..T+9.
  - `ack` in T+10.
  - IDLE in T+11.
- Throughput: one transaction per 11 cycles. The earliest next grant is sampled in T+11.
- Reset values:
  - State IDLE; `gnt` = 0; `busy` = 0; `ack0` = `ack1` = 0.
  - `rdata0` = `rdata1` = 0.
  - `pad_addr` = `pad_dout` = `pad_oe` = 0.
  - `last_grant` = port 1; hold-off cleared.
- Reset mid-transaction:
  - State is IDLE and all pads are 0 on the cycle after `rst` is sampled.
  - No `ack` is issued for the aborted transaction.
  - `rdata` keeps its reset value of 0; partial read bytes are never exposed.
- `rst` has priority over every other event, including a DONE cycle. An `ack` is suppressed if `rst` is sampled in DONE.

## Test plan
- **Write, port 0:** `addr0`=0x12345678, `wdata0`=0xA1B2C3D4, `we0`=1, `req0` at T.
  - `pad_addr` = 78, 56, 34, 12 in T+1..T+4, then 81 in T+5.
  - `pad_dout` = D4, C3, B2, A1 with `pad_oe` = FF in T+6..T+9.
  - `ack0` = 1 in T+10 only; `rdata0` unchanged.
- **Read, port 1:** `addr1`=0x00000010, `we1`=0.
  - CMD byte = 80.
  - `pad_din` = EF, BE, AD, DE in DATA cycles, with `pad_oe` = 00 throughout.
  - `rdata1` = 0xDEADBEEF and `ack1` = 1 in T+10.
- **Tie after reset:** `req0` and `req1` both rise at T.
  - `gnt` = 01, `ack0` at T+10.
  - `gnt` = 10 from T+12, `ack1` at T+21.
- **Continuous contention:** both `req` held high for 6 transactions.
  - Grant order is 0, 1, 0, 1, 0, 1.
  - The `ack` cycles are 11 apart.
- **Reset mid-write:** assert `rst` for one cycle at T+7 (DATA, k=1).
  - At T+8: `pad_oe` = 0, `pad_dout` = 0, `busy` = 0.
  - No `ack0`.
  - With `req0` still high, the transaction restarts with ADDR at T+9.
- **Short request pulse:** `req0` high only in cycle T, read with `pad_din` = 0x5A each DATA cycle.
  - Transaction completes: `ack0` at T+10, `rdata0` = 0x5A5A5A5A.
  - No second grant follows.

Source files
------------

// File: rtl/ext_bus_sequencer.sv
// ext_bus_sequencer
// Round-robin arbiter plus byte-serial sequencer that shares one 8-bit
// external bus between two 32-bit requesters. A granted transaction is
// sent as 4 address bytes (LSB first), one command byte and 4 data bytes
// (LSB first). It then completes with a one-cycle ack and, for reads, the
// assembled read word.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req0/1, we0/1            request (level) and write flag per port
//   addr0/1, wdata0/1        address and write data per port (sampled at grant)
//   ack0/1, rdata0/1         completion pulse and read result per port
//   gnt, busy                one-hot owner (0 in IDLE), sequencer active
//   pad_addr                 address/command byte lane
//   pad_dout, pad_din        write / read data byte lanes
//   pad_oe                   data lane output enable (8'hFF or 8'h00)
module ext_bus_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic [7:0]  pad_addr,
  output logic [7:0]  pad_dout,
  input  logic [7:0]  pad_din,
  output logic [7:0]  pad_oe
);

  typedef enum logic [2:0] {IDLE, ADDR, CMD, DATA, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  k, k_nxt;
  logic [1:0]  gnt_q, gnt_nxt;
  logic        last_grant, last_grant_nxt;  // 1 = port 1 was granted last
  logic [1:0]  holdoff;                     // port acked in the previous cycle
  logic [1:0]  elig;
  logic        win_valid;
  logic        win_port;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [23:0] rbuf;                        // first three read bytes, shifted in LSB first

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Arbitration and next-state
  always_comb begin
    state_nxt      = state;
    k_nxt          = k;
    gnt_nxt        = gnt_q;
    last_grant_nxt = last_grant;
    elig           = {req1, req0} & ~holdoff;
    win_valid      = |elig;
    if (elig == 2'b11) win_port = ~last_grant;
    else               win_port = elig[1];

    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nxt      = ADDR;
          k_nxt          = 2'd0;
          gnt_nxt        = win_port ? 2'b10 : 2'b01;
          last_grant_nxt = win_port;
        end
      end
      ADDR: begin
        k_nxt = k + 2'd1;
        if (k == 2'd3) state_nxt = CMD;
      end
      CMD: begin
        state_nxt = DATA;
        k_nxt     = 2'd0;
      end
      DATA: begin
        k_nxt = k + 2'd1;
        if (k == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= 2'd0;
      gnt_q      <= 2'b00;
      last_grant <= 1'b1;
      holdoff    <= 2'b00;
    end else begin
      state      <= state_nxt;
      k          <= k_nxt;
      gnt_q      <= gnt_nxt;
      last_grant <= last_grant_nxt;
      holdoff    <= (state == DONE) ? gnt_q : 2'b00;
    end
  end

  // Transaction capture; only meaningful outside IDLE, so no reset needed
  always_ff @(posedge clk) begin
    if (state == IDLE && win_valid) begin
      addr_q  <= win_port ? addr1  : addr0;
      wdata_q <= win_port ? wdata1 : wdata0;
      we_q    <= win_port ? we1    : we0;
    end
    if (state == DATA && !we_q) rbuf <= {pad_din, rbuf[23:8]};
  end

  // Read results commit on entry to DONE, so a reset before then never
  // exposes a partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0 <= 32'd0;
      rdata1 <= 32'd0;
    end else if (state == DATA && k == 2'd3 && !we_q) begin
      if (gnt_q[0]) rdata0 <= {pad_din, rbuf};
      if (gnt_q[1]) rdata1 <= {pad_din, rbuf};
    end
  end

  // Moore output decode
  always_comb begin
    ack0     = 1'b0;
    ack1     = 1'b0;
    pad_addr = 8'h00;
    pad_dout = 8'h00;
    pad_oe   = 8'h00;
    case (state)
      ADDR: pad_addr = byte_sel(addr_q, k);
      CMD:  pad_addr = {1'b1, 6'b000000, we_q};
      DATA: begin
        if (we_q) begin
          pad_oe   = 8'hFF;
          pad_dout = byte_sel(wdata_q, k);
        end
      end
      DONE: begin
        ack0 = gnt_q[0];
        ack1 = gnt_q[1];
      end
      default: ;
    endcase
  end

  assign gnt  = gnt_q;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ext_bus_sequencer.sv
module tb_ext_bus_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  gnt;
  logic        busy;
  logic [7:0]  pad_addr, pad_dout, pad_din, pad_oe;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_rd0 = 32'd0;
  logic [31:0] exp_rd1 = 32'd0;

  always #5 clk = ~clk;

  ext_bus_sequencer dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .gnt(gnt), .busy(busy),
    .pad_addr(pad_addr), .pad_dout(pad_dout), .pad_din(pad_din), .pad_oe(pad_oe)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bsel(input logic [31:0] w, input int i);
    return w[i*8 +: 8];
  endfunction

  // Caller is in the IDLE cycle T where the winning request is sampled.
  // Checks T+1..T+10 cycle by cycle and the IDLE cycle T+11, returning in T+11.
  task automatic run_txn(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] din, input bit drop);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1 && drop) begin
        if (port) req1 = 1'b0;
        else      req0 = 1'b0;
      end
      pad_din = (c >= 6 && c <= 9) ? bsel(din, c - 6) : 8'h33;
      chk("gnt", {30'd0, gnt}, port ? 32'd2 : 32'd1);
      chk("busy", {31'd0, busy}, 32'd1);
      chk("pad_addr", {24'd0, pad_addr},
          c <= 4 ? {24'd0, bsel(addr, c - 1)} : (c == 5 ? {24'd0, 7'b1000000, we} : 32'd0));
      chk("pad_oe", {24'd0, pad_oe}, (we && c >= 6 && c <= 9) ? 32'hFF : 32'd0);
      chk("pad_dout", {24'd0, pad_dout},
          (we && c >= 6 && c <= 9) ? {24'd0, bsel(wdata, c - 6)} : 32'd0);
      chk("ack0", {31'd0, ack0}, (c == 10 && !port) ? 32'd1 : 32'd0);
      chk("ack1", {31'd0, ack1}, (c == 10 && port) ? 32'd1 : 32'd0);
      if (c == 10) begin
        if (!we) begin
          if (port) exp_rd1 = din;
          else      exp_rd0 = din;
        end
        chk("rdata0", rdata0, exp_rd0);
        chk("rdata1", rdata1, exp_rd1);
      end
    end
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_gnt", {30'd0, gnt}, 32'd0);
    chk("idle_ack", {30'd0, ack1, ack0}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    pad_din = 8'h00;
    step();
    step();
    // reset state
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_pads", {8'd0, pad_addr, pad_dout, pad_oe}, 32'd0);
    rst = 1'b0;

    // Write, port 0 (req dropped after grant still completes)
    addr0 = 32'h12345678; wdata0 = 32'hA1B2C3D4; we0 = 1'b1; req0 = 1'b1;
    run_txn(1'b0, 1'b1, 32'h12345678, 32'hA1B2C3D4, 32'h0, 1'b1);

    // Read, port 1
    addr1 = 32'h00000010; we1 = 1'b0; req1 = 1'b1;
    run_txn(1'b1, 1'b0, 32'h00000010, 32'h0, 32'hDEADBEEF, 1'b1);

    // Reset, then tie and continuous contention: order 0,1,0,1,0,1
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_rd0 = 32'd0; exp_rd1 = 32'd0;
    chk("rst2_rdata1", rdata1, 32'd0);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    addr0 = 32'h0000A000; wdata0 = 32'h01234567; we0 = 1'b1;
    addr1 = 32'h0000B000; we1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    run_txn(1'b0, 1'b1, 32'h0000A000, 32'h01234567, 32'h0, 1'b0);
    addr0 = 32'h0000A004; we0 = 1'b0;
    run_txn(1'b1, 1'b0, 32'h0000B000, 32'h0, 32'h01020304, 1'b0);
    addr1 = 32'h0000B004; wdata1 = 32'h89ABCDEF; we1 = 1'b1;
    run_txn(1'b0, 1'b0, 32'h0000A004, 32'h0, 32'hA5A55A5A, 1'b0);
    addr0 = 32'h0000A008; wdata0 = 32'hFFFF0000; we0 = 1'b1;
    run_txn(1'b1, 1'b1, 32'h0000B004, 32'h89ABCDEF, 32'h0, 1'b0);
    addr1 = 32'h0000B008; we1 = 1'b0;
    run_txn(1'b0, 1'b1, 32'h0000A008, 32'hFFFF0000, 32'h0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h0000B008, 32'h0, 32'hFEDCBA98, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("quiet_busy", {31'd0, busy}, 32'd0);

    // Reset mid-write at T+7 (DATA, k=1)
    addr0 = 32'hCAFEF00D; wdata0 = 32'h11223344; we0 = 1'b1; req0 = 1'b1;
    for (int c = 1; c <= 7; c++) step();
    chk("mid_oe", {24'd0, pad_oe}, 32'hFF);
    chk("mid_dout", {24'd0, pad_dout}, 32'h33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_rd0 = 32'd0; exp_rd1 = 32'd0;
    chk("abort_oe", {24'd0, pad_oe}, 32'd0);
    chk("abort_dout", {24'd0, pad_dout}, 32'd0);
    chk("abort_addr", {24'd0, pad_addr}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ack0", {31'd0, ack0}, 32'd0);
    chk("abort_rdata0", rdata0, 32'd0);
    run_txn(1'b0, 1'b1, 32'hCAFEF00D, 32'h11223344, 32'h0, 1'b1);

    // Short request pulse, read; one idle cycle first to clear the hold-off
    step();
    addr0 = 32'h00000040; we0 = 1'b0; req0 = 1'b1;
    run_txn(1'b0, 1'b0, 32'h00000040, 32'h0, 32'h5A5A5A5A, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("no_regrant", {31'd0, busy}, 32'd0);
    end
    chk("pulse_rdata0", rdata0, 32'h5A5A5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
